// File: rtl/demux_1to4_reg_if.sv
// Handshake bundle for the registered 1-to-4 demultiplexer.
// The master side drives words and consumer readies; the slave side is the demux itself.
interface demux_1to4_reg_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [W-1:0] out_c;
  logic [W-1:0] out_d;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: one holding register per output channel,
// valid/ready on every port and a wrapping accepted-word counter per channel.
module demux_1to4_reg #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  demux_1to4_reg_if.slave      bus,
  input  logic                 cnt_clr,
  output logic [4*CNT_W-1:0]   cnt
);

  logic [3:0]       r_full;
  logic [W-1:0]     r_data [4];
  logic [CNT_W-1:0] r_cnt  [4];

  logic             w_in_ready;
  logic             w_acc;
  logic [3:0]       w_push;
  logic [3:0]       w_pop;
  logic [4*CNT_W-1:0] w_cnt;

  // Accept decision: a full channel may still take a word when it drains this cycle.
  always_comb begin
    w_in_ready = 1'b0;
    w_acc      = 1'b0;
    w_push     = 4'b0000;
    w_pop      = r_full & bus.out_ready;
    w_in_ready = ~r_full[bus.in_sel] | bus.out_ready[bus.in_sel];
    w_acc      = bus.in_valid & w_in_ready;
    if (w_acc) begin
      w_push[bus.in_sel] = 1'b1;
    end else begin
      w_push = 4'b0000;
    end
  end

  // Holding registers and full flags; a push wins over a same-cycle pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) begin
          r_data[i] <= bus.in_data;
          r_full[i] <= 1'b1;
        end else if (w_pop[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Per-channel accepted-word counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) begin
          r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Pack the counter slices, channel a in the low slice.
  always_comb begin
    w_cnt = {(4*CNT_W){1'b0}};
    for (int i = 0; i < 4; i++) begin
      w_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_full;
  assign bus.out_a     = r_data[0];
  assign bus.out_b     = r_data[1];
  assign bus.out_c     = r_data[2];
  assign bus.out_d     = r_data[3];
  assign cnt           = w_cnt;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed plus randomized bench for demux_1to4_reg, checked against a
// channel-occupancy reference model built from the handshake rules.
module tb_demux_1to4_reg;
  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rstn;
  logic cnt_clr;
  logic [4*CNT_W-1:0] cnt;

  demux_1to4_reg_if #(.W(W)) bus ();

  demux_1to4_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: occupancy, last word delivered, and count of accepts per channel.
  bit           m_full [4];
  logic [W-1:0] m_word [4];
  int           m_cnt  [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    logic [4*CNT_W-1:0] ec;
    for (int i = 0; i < 4; i++) begin
      ev[i] = m_full[i];
      ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(ev));
    chk({tag, "_a"}, 64'(bus.out_a), 64'(m_word[0]));
    chk({tag, "_b"}, 64'(bus.out_b), 64'(m_word[1]));
    chk({tag, "_c"}, 64'(bus.out_c), 64'(m_word[2]));
    chk({tag, "_d"}, 64'(bus.out_d), 64'(m_word[3]));
    chk({tag, "_cnt"}, 64'(cnt), 64'(ec));
  endtask

  // Called at posedge+1: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] ordy, input logic clr);
    bit rdy;
    bit acc;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    rdy = !m_full[s] || ordy[s];
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(rdy));
    acc = v && rdy;
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (acc) begin
      m_cnt[s] = (m_cnt[s] + 1) % (1 << CNT_W);
    end
    for (int i = 0; i < 4; i++) begin
      if (acc && s == 2'(i)) begin
        m_full[i] = 1'b1;
        m_word[i] = d;
      end else if (m_full[i] && ordy[i]) begin
        m_full[i] = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rstn          = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'h0;

    // Reset state, including in_ready reading 1 while held in reset.
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_outputs("rst");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rel_valid", 64'(bus.out_valid), 64'd0);
    chk("rel_cnt", 64'(cnt), 64'd0);

    // Route one word to each channel.
    for (int i = 0; i < 4; i++) step("route", 1'b1, 2'(i), 4'(i + 1), 4'hF, 1'b0);
    step("drain", 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
    chk("route_cnt", 64'(cnt), 64'h01010101);
    chk("route_d", 64'(bus.out_d), 64'd4);

    // Stall channel c, then release it while the second word waits.
    step("c_push5", 1'b1, 2'd2, 4'd5, 4'h0, 1'b0);
    step("c_push6_stall", 1'b1, 2'd2, 4'd6, 4'h0, 1'b0);
    chk("c_held5", 64'(bus.out_c), 64'd5);
    step("c_push6_pass", 1'b1, 2'd2, 4'd6, 4'b0100, 1'b0);
    chk("c_now6", 64'(bus.out_c), 64'd6);

    // Stalled c does not block b.
    step("b_push9", 1'b1, 2'd1, 4'd9, 4'h0, 1'b0);
    chk("b_is9", 64'(bus.out_b), 64'd9);
    chk("c_still_full", 64'(bus.out_valid[2]), 64'd1);

    // Counter wrap on channel d, then clear racing an accept.
    step("clr", 1'b0, 2'd0, 4'h0, 4'hF, 1'b1);
    for (int i = 0; i < 255; i++) step("d_fill", 1'b1, 2'd3, 4'(i), 4'hF, 1'b0);
    chk("cnt_d_255", 64'(cnt[4*CNT_W-1 -: CNT_W]), 64'd255);
    step("d_wrap", 1'b1, 2'd3, 4'hA, 4'hF, 1'b0);
    chk("cnt_d_wrap", 64'(cnt[4*CNT_W-1 -: CNT_W]), 64'd0);
    step("a_inc", 1'b1, 2'd0, 4'h3, 4'hF, 1'b0);
    step("clr_vs_acc", 1'b1, 2'd0, 4'h7, 4'hF, 1'b1);
    chk("clr_wins", 64'(cnt), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 31) == 0));
    end

    // Fill all channels, then assert reset between clock edges.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 2'(i), 4'(8 + i), 4'h0, 1'b0);
    chk("full_all", 64'(bus.out_valid), 64'hF);
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async_in_ready", 64'(bus.in_ready), 64'd1);
    check_outputs("async_rst");
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 2'd1, 4'h5, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
